// File: rtl/s38417_match_lock.sv
// s38417_match_lock
//   Multi-channel source-select comparator with a registered mismatch flag
//   and a match-lock FSM.
//   Each channel picks one of SRC source bits through a shared one-hot select.
//   The picked bit is compared against that channel's reference bit.
//   A consecutive full-match counter moves the FSM from ARMED to LOCKED.
//   Optional feature macro: S38417_SEL_CHECK_EN
//     - Adds the sel_err output, which flags a select that is not one-hot.
//     - While the select is illegal, ARMED treats the cycle as a mismatch.
module s38417_match_lock #(
  parameter int CH       = 10,
  parameter int SRC      = 3,
  parameter int THRESH_W = 4
) (
  input  logic                CK,
  input  logic                RST,
  input  logic                hold_a,
  input  logic                hold_b,
  input  logic [SRC-1:0]      sel,
  input  logic [CH*SRC-1:0]   src_data,
  input  logic [CH-1:0]       ref_bits,
  input  logic [CH-1:0]       ch_mask,
  input  logic [THRESH_W-1:0] threshold,
  input  logic                arm,
  input  logic                clear,
  output logic                mismatch_q,
  output logic [THRESH_W-1:0] hit_cnt,
  output logic [1:0]          state_q,
  output logic                locked
`ifdef S38417_SEL_CHECK_EN
  ,
  output logic                sel_err
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARMED  = 2'b01,
    LOCKED = 2'b10
  } state_t;

  localparam logic [THRESH_W-1:0] THR_ONE = THRESH_W'(1);

  state_t              state;
  logic [CH-1:0]       sel_bit;
  logic                mm;
  logic                hold;
  logic                cnt_fail;
  logic [THRESH_W-1:0] eff_thr;
  logic [THRESH_W-1:0] hit_inc;

`ifdef S38417_SEL_CHECK_EN
  localparam logic [SRC-1:0] SEL_ONE = SRC'(1);
  logic sel_onehot;
`endif

  // Pick the selected source bit for every channel; a multi-hot select ORs
  // the chosen sources together and an all-zero select yields 0.
  always_comb begin
    sel_bit = '0;
    for (int c = 0; c < CH; c++) begin
      for (int s = 0; s < SRC; s++) begin
        sel_bit[c] = sel_bit[c] | (sel[s] & src_data[c*SRC+s]);
      end
    end
  end

  // Any enabled channel disagreeing with its reference is a mismatch.
  assign mm   = |(ch_mask & (sel_bit ^ ref_bits));
  assign hold = hold_a & hold_b;

  // A zero threshold behaves like 1 so that one clean cycle is enough to lock.
  assign eff_thr = (threshold == '0) ? THR_ONE : threshold;

  // The match counter saturates at all-ones instead of wrapping.
  assign hit_inc = (&hit_cnt) ? hit_cnt : (hit_cnt + THR_ONE);

`ifdef S38417_SEL_CHECK_EN
  // One-hot means non-zero with exactly one bit set.
  assign sel_onehot = (sel != '0) && ((sel & (sel - SEL_ONE)) == '0);
  assign cnt_fail   = mm | ~sel_onehot;
`else
  assign cnt_fail   = mm;
`endif

  assign state_q = state;

  // Registered compare flag plus lock FSM.
  // Priority on each edge: reset, then hold freezes everything, then clear,
  // then the normal FSM step.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      mismatch_q <= 1'b0;
      hit_cnt    <= '0;
      state      <= IDLE;
      locked     <= 1'b0;
`ifdef S38417_SEL_CHECK_EN
      sel_err    <= 1'b0;
`endif
    end else if (!hold) begin
      mismatch_q <= mm;
`ifdef S38417_SEL_CHECK_EN
      sel_err    <= ~sel_onehot;
`endif
      if (clear) begin
        state   <= IDLE;
        hit_cnt <= '0;
        locked  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            hit_cnt <= '0;
            if (arm) begin
              state <= ARMED;
            end
          end
          ARMED: begin
            if (cnt_fail) begin
              hit_cnt <= '0;
            end else begin
              hit_cnt <= hit_inc;
              if (hit_inc >= eff_thr) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end
          end
          LOCKED: begin
            locked <= 1'b1;
          end
          default: begin
            state   <= IDLE;
            hit_cnt <= '0;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_s38417_match_lock.sv
// Testbench for s38417_match_lock.
// A behavioural model computes the expected next outputs whenever stimulus is
// driven; the expectation is queued and compared after the following edge.
// Compile with +define+S38417_SEL_CHECK_EN to also exercise sel_err.
module tb_s38417_match_lock;

  localparam int CH       = 10;
  localparam int SRC      = 3;
  localparam int THRESH_W = 4;

  typedef struct packed {
    logic                mism;
    logic [THRESH_W-1:0] hit;
    logic [1:0]          st;
    logic                lk;
    logic                serr;
  } exp_t;

  logic                CK;
  logic                RST;
  logic                hold_a;
  logic                hold_b;
  logic [SRC-1:0]      sel;
  logic [CH*SRC-1:0]   src_data;
  logic [CH-1:0]       ref_bits;
  logic [CH-1:0]       ch_mask;
  logic [THRESH_W-1:0] threshold;
  logic                arm;
  logic                clear;
  logic                mismatch_q;
  logic [THRESH_W-1:0] hit_cnt;
  logic [1:0]          state_q;
  logic                locked;
  logic                sel_err_obs;

  int   checkCount;
  int   failCount;
  exp_t model;
  exp_t expQ[$];

  s38417_match_lock #(.CH(CH), .SRC(SRC), .THRESH_W(THRESH_W)) dut (
    .CK(CK),
    .RST(RST),
    .hold_a(hold_a),
    .hold_b(hold_b),
    .sel(sel),
    .src_data(src_data),
    .ref_bits(ref_bits),
    .ch_mask(ch_mask),
    .threshold(threshold),
    .arm(arm),
    .clear(clear),
    .mismatch_q(mismatch_q),
    .hit_cnt(hit_cnt),
    .state_q(state_q),
    .locked(locked)
`ifdef S38417_SEL_CHECK_EN
    ,
    .sel_err(sel_err_obs)
`endif
  );

`ifndef S38417_SEL_CHECK_EN
  assign sel_err_obs = 1'b0;
`endif

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Source data whose selected bits equal the reference; other bits random.
  function automatic logic [CH*SRC-1:0] makeSrc(input logic [CH-1:0] r, input logic [SRC-1:0] s);
    logic [CH*SRC-1:0] d;
    d = {$urandom, $urandom};
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < SRC; k++)
        if (s[k]) d[c*SRC+k] = r[c];
    return d;
  endfunction

  function automatic logic isOneHot(input logic [SRC-1:0] s);
    int n;
    n = 0;
    for (int k = 0; k < SRC; k++) n += int'(s[k]);
    return n == 1;
  endfunction

  // Expected register values after the next edge, given the current model state.
  function automatic exp_t nextModel(input exp_t cur);
    exp_t n;
    logic mmv;
    logic pick;
    logic bad;
    int   thr;
    int   inc;
    n   = cur;
    mmv = 1'b0;
    for (int c = 0; c < CH; c++) begin
      pick = 1'b0;
      for (int k = 0; k < SRC; k++) if (sel[k] && src_data[c*SRC+k]) pick = 1'b1;
      if (ch_mask[c] && (pick != ref_bits[c])) mmv = 1'b1;
    end
    if (hold_a && hold_b) return n;
    n.mism = mmv;
`ifdef S38417_SEL_CHECK_EN
    n.serr = !isOneHot(sel);
    bad    = mmv || !isOneHot(sel);
`else
    bad    = mmv;
`endif
    if (clear) begin
      n.st  = 2'b00;
      n.hit = '0;
    end else if (cur.st == 2'b00) begin
      n.hit = '0;
      if (arm) n.st = 2'b01;
    end else if (cur.st == 2'b01) begin
      if (bad) n.hit = '0;
      else begin
        inc   = (int'(cur.hit) == 15) ? 15 : int'(cur.hit) + 1;
        thr   = (threshold == 0) ? 1 : int'(threshold);
        n.hit = THRESH_W'(inc);
        if (inc >= thr) n.st = 2'b10;
      end
    end
    n.lk = (n.st == 2'b10);
    return n;
  endfunction

  // Push the expectation for the current inputs, clock once, then compare.
  task automatic applyStimulus(input string tag);
    exp_t e;
    expQ.push_back(nextModel(model));
    @(posedge CK);
    #1;
    e     = expQ.pop_front();
    model = e;
    checkOutput({tag, ".mismatch_q"}, 32'(mismatch_q), 32'(e.mism));
    checkOutput({tag, ".hit_cnt"}, 32'(hit_cnt), 32'(e.hit));
    checkOutput({tag, ".state_q"}, 32'(state_q), 32'(e.st));
    checkOutput({tag, ".locked"}, 32'(locked), 32'(e.lk));
`ifdef S38417_SEL_CHECK_EN
    checkOutput({tag, ".sel_err"}, 32'(sel_err_obs), 32'(e.serr));
`endif
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".mismatch_q"}, 32'(mismatch_q), 32'd0);
    checkOutput({tag, ".hit_cnt"}, 32'(hit_cnt), 32'd0);
    checkOutput({tag, ".state_q"}, 32'(state_q), 32'd0);
    checkOutput({tag, ".locked"}, 32'(locked), 32'd0);
    checkOutput({tag, ".sel_err"}, 32'(sel_err_obs), 32'd0);
  endtask

  task automatic matchCycle(input string tag);
    src_data = makeSrc(ref_bits, sel);
    applyStimulus(tag);
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    model      = '0;
    RST        = 1'b1;
    hold_a     = 1'b0;
    hold_b     = 1'b0;
    sel        = 3'b001;
    ref_bits   = 10'h2B5;
    ch_mask    = '1;
    src_data   = '0;
    threshold  = 4'd3;
    arm        = 1'b0;
    clear      = 1'b0;
    #12;
    checkResetOutputs("reset");
    RST = 1'b0;

    // Compare path: match, flip channel 3, then mask channel 3 out.
    matchCycle("match");
    checkOutput("match_direct", 32'(mismatch_q), 32'd0);
    src_data    = makeSrc(ref_bits, sel);
    src_data[9] = ~src_data[9];
    applyStimulus("flip3");
    checkOutput("flip3_direct", 32'(mismatch_q), 32'd1);
    ch_mask[3] = 1'b0;
    applyStimulus("mask3");
    checkOutput("mask3_direct", 32'(mismatch_q), 32'd0);
    ch_mask = '0;
    src_data = ~makeSrc(ref_bits, sel);
    applyStimulus("mask_none");
    ch_mask = '1;

    // Lock with threshold 3.
    threshold = 4'd3;
    arm = 1'b1;
    matchCycle("arm");
    arm = 1'b0;
    matchCycle("hit1");
    checkOutput("hit1_direct", 32'(hit_cnt), 32'd1);
    matchCycle("hit2");
    matchCycle("hit3");
    checkOutput("lock_direct", 32'(state_q), 32'd2);
    checkOutput("lock_locked", 32'(locked), 32'd1);
    src_data = ~makeSrc(ref_bits, sel);
    applyStimulus("locked_mm");
    clear = 1'b1;
    matchCycle("clear_locked");
    checkOutput("clear_hit", 32'(hit_cnt), 32'd0);
    clear = 1'b0;

    // Mismatch after two hits resets the count but stays ARMED.
    arm = 1'b1;
    matchCycle("rearm");
    arm = 1'b0;
    matchCycle("r_hit1");
    matchCycle("r_hit2");
    src_data = ~makeSrc(ref_bits, sel);
    applyStimulus("r_mm");
    checkOutput("r_mm_hit", 32'(hit_cnt), 32'd0);
    checkOutput("r_mm_state", 32'(state_q), 32'd1);

    // Hold freezes everything while inputs toggle.
    matchCycle("h_hit1");
    matchCycle("h_hit2");
    hold_a = 1'b1;
    hold_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src_data = {$urandom, $urandom};
      clear    = i[0];
      sel      = 3'b010;
      applyStimulus("hold");
    end
    checkOutput("hold_hit", 32'(hit_cnt), 32'd2);
    clear  = 1'b0;
    hold_b = 1'b0;
    sel    = 3'b001;
    matchCycle("half_hold");
    checkOutput("half_hold_lock", 32'(state_q), 32'd2);
    hold_a = 1'b0;

    // Threshold 0 locks after one matching cycle; arm+clear in IDLE stays IDLE.
    clear = 1'b1;
    matchCycle("clr");
    clear     = 1'b0;
    threshold = 4'd0;
    arm       = 1'b1;
    clear     = 1'b1;
    matchCycle("arm_clear");
    checkOutput("arm_clear_state", 32'(state_q), 32'd0);
    clear = 1'b0;
    matchCycle("arm0");
    arm = 1'b0;
    matchCycle("thr0_lock");
    checkOutput("thr0_state", 32'(state_q), 32'd2);

    // Multi-hot and zero select in ARMED.
    clear = 1'b1;
    matchCycle("clr2");
    clear     = 1'b0;
    threshold = 4'd8;
    arm       = 1'b1;
    matchCycle("arm2");
    arm = 1'b0;
    matchCycle("ms_hit1");
    sel = 3'b011;
    matchCycle("multihot");
    sel = 3'b010;
    matchCycle("sel010");
    sel = 3'b000;
    ref_bits = 10'h000;
    src_data = {$urandom, $urandom};
    applyStimulus("sel0_ref0");
    ref_bits = 10'h2B5;
    applyStimulus("sel0_refx");
    sel = 3'b001;

    // Randomised traffic with a bias toward matches.
    for (int i = 0; i < 60; i++) begin
      hold_a    = ($urandom_range(0, 3) == 0);
      hold_b    = ($urandom_range(0, 3) == 0);
      clear     = ($urandom_range(0, 9) == 0);
      arm       = ($urandom_range(0, 3) == 0);
      threshold = THRESH_W'($urandom_range(0, 5));
      sel       = ($urandom_range(0, 5) == 0) ? SRC'($urandom) : SRC'(1 << $urandom_range(0, 2));
      ref_bits  = CH'($urandom);
      ch_mask   = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '1;
      src_data  = makeSrc(ref_bits, sel);
      if ($urandom_range(0, 4) == 0) src_data = {$urandom, $urandom};
      applyStimulus("rand");
    end

    // Drive to LOCKED, then assert reset between edges.
    hold_a    = 1'b0;
    hold_b    = 1'b0;
    clear     = 1'b1;
    sel       = 3'b100;
    threshold = 4'd1;
    matchCycle("pre_clr");
    clear = 1'b0;
    arm   = 1'b1;
    matchCycle("pre_arm");
    arm = 1'b0;
    matchCycle("pre_lock");
    checkOutput("pre_lock_state", 32'(state_q), 32'd2);
    #2;
    RST = 1'b1;
    #1;
    checkResetOutputs("async_rst");
    model = '0;
    @(negedge CK);
    RST = 1'b0;
    matchCycle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
